fwd_hazard_unit: RTL and testbench

Parametrised operand-forwarding and load-use hazard unit for the pipelined core. It replaces the per-operand forwarding muxes and their externally computed select codes. It keeps its own shift-register record of the destination registers in flight in the EX..WB stages. From that record it resolves NPORTS decode-stage source operands, and raises a stall (bubble insertion) on load-use hazards. It sits between the register file read ports and the ID/EX pipeline register and counts stall cycles for performance monitoring.

---
 rtl/fwd_hazard_unit.sv | 52 +++++
 tb/tb_fwd_hazard_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding and load-use stall driven by a shift-register record of in-flight destinations
module fwd_hazard_unit #(
  parameter int XLEN = 32,
  parameter int NPORTS = 2,
  parameter int REG_AW = 5,
  parameter int DEPTH = 3,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [NPORTS*REG_AW-1:0] id_rs,
  input  logic [NPORTS*XLEN-1:0]   id_rD,
  input  logic [REG_AW-1:0]        id_rd,
  input  logic                     id_we,
  input  logic                     id_is_load,
  input  logic [DEPTH*XLEN-1:0]    stage_wD,
  input  logic                     flush,
  output logic [NPORTS*XLEN-1:0]   real_rD,
  output logic [NPORTS*2-1:0]      fwd_src,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_cnt
);
  logic [DEPTH-1:0] trk_v, trk_we, trk_ld;
  logic [DEPTH*REG_AW-1:0] trk_rd;
  logic [NPORTS-1:0] hz;
  always_comb begin
    hz = '0;
    real_rD = id_rD;
    fwd_src = '0;
    for (int p = 0; p < NPORTS; p++)
      for (int k = DEPTH - 1; k >= 0; k--)
        if (trk_v[k] && trk_we[k] && trk_rd[k*REG_AW +: REG_AW] != '0 &&
            trk_rd[k*REG_AW +: REG_AW] == id_rs[p*REG_AW +: REG_AW]) begin
          hz[p] = trk_ld[k] && k < LOAD_LAT;
          real_rD[p*XLEN +: XLEN] = hz[p] ? id_rD[p*XLEN +: XLEN] : stage_wD[k*XLEN +: XLEN];
          fwd_src[p*2 +: 2] = hz[p] ? 2'd0 : k >= 2 ? 2'd3 : 2'(k + 1);
        end
  end
  assign stall = id_valid & ~flush & |hz;
  always_ff @(posedge clk) begin
    trk_rd <= {trk_rd[(DEPTH-1)*REG_AW-1:0], id_rd};
    trk_we <= {trk_we[DEPTH-2:0], id_we};
    trk_ld <= {trk_ld[DEPTH-2:0], id_is_load};
    trk_v <= (rst || flush) ? '0 : {trk_v[DEPTH-2:0], id_valid & ~stall};
    if (rst)
      stall_cnt <= '0;
    else if (stall && ~&stall_cnt)
      stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed plus random stimulus against an in-flight instruction list model
module tb_fwd_hazard_unit;
  localparam int CW = 6;
  logic clk = 0, rst = 1, id_valid = 0, id_we = 0, id_is_load = 0, flush = 0;
  logic [9:0] id_rs = '0;
  logic [63:0] id_rD = '0;
  logic [4:0] id_rd = '0;
  logic [95:0] stage_wD = '0;
  logic [63:0] real_rD;
  logic [3:0] fwd_src;
  logic stall;
  logic [CW-1:0] stall_cnt;
  int pass_cnt = 0, total_cnt = 0;
  bit m_v[3], m_we[3], m_ld[3];
  logic [4:0] m_rd[3];
  int m_cnt = 0;
  bit e_stall;
  logic [31:0] e_d[2];
  logic [1:0] e_s[2];

  fwd_hazard_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rD(id_rD),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .stage_wD(stage_wD),
    .flush(flush), .real_rD(real_rD), .fwd_src(fwd_src), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic chk_model();
    bit hz;
    logic [4:0] rs;
    #1;
    hz = 0;
    for (int p = 0; p < 2; p++) begin
      rs = id_rs[p*5 +: 5];
      e_d[p] = id_rD[p*32 +: 32];
      e_s[p] = 0;
      for (int k = 0; k < 3; k++)
        if (rs != 0 && m_v[k] && m_we[k] && m_rd[k] == rs) begin
          if (m_ld[k] && k < 2) hz = 1;
          else begin
            e_d[p] = stage_wD[k*32 +: 32];
            e_s[p] = (k >= 2) ? 2'd3 : 2'(k + 1);
          end
          break;
        end
    end
    e_stall = id_valid && !flush && hz;
    chk("stall", stall, e_stall);
    chk("stall_cnt", stall_cnt, m_cnt);
    if (!e_stall) begin
      chk("real_rD0", real_rD[31:0], e_d[0]);
      chk("real_rD1", real_rD[63:32], e_d[1]);
      chk("fwd_src0", fwd_src[1:0], e_s[0]);
      chk("fwd_src1", fwd_src[3:2], e_s[1]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst && e_stall && m_cnt < (1 << CW) - 1) m_cnt++;
    if (rst) m_cnt = 0;
    for (int k = 2; k > 0; k--) begin
      m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_we[k] = m_we[k-1]; m_ld[k] = m_ld[k-1];
    end
    m_v[0] = id_valid && !e_stall;
    m_rd[0] = id_rd; m_we[0] = id_we; m_ld[0] = id_is_load;
    if (rst || flush) for (int k = 0; k < 3; k++) m_v[k] = 0;
    #1;
  endtask

  task automatic cyc();
    chk_model();
    tick();
  endtask

  task automatic drive(bit v, logic [4:0] r0, logic [4:0] r1, logic [4:0] rd, bit we, bit ld);
    id_valid = v; id_rs = {r1, r0}; id_rd = rd; id_we = we; id_is_load = ld;
    id_rD = {$urandom, $urandom};
    stage_wD = {$urandom, $urandom, $urandom};
  endtask

  initial begin
    @(posedge clk);
    #1 rst = 0;
    drive(0, 0, 0, 0, 0, 0);
    chk_model();
    chk("rst_stall", stall, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_rD", real_rD, id_rD);
    chk("rst_src", fwd_src, 0);
    tick();
    drive(1, 0, 0, 5, 1, 0); cyc();
    drive(1, 5, 0, 6, 1, 0);
    stage_wD[31:0] = 32'h1234;
    chk_model();
    chk("alu_d", real_rD[31:0], 32'h1234);
    chk("alu_src", fwd_src[1:0], 1);
    chk("alu_stall", stall, 0);
    tick();
    drive(1, 0, 0, 7, 1, 0); cyc();
    drive(1, 0, 0, 1, 1, 0); cyc();
    drive(1, 0, 0, 7, 1, 0); cyc();
    drive(1, 0, 7, 2, 1, 0);
    stage_wD = {32'hBBBB_0002, 32'h0, 32'hAAAA_0000};
    chk_model();
    chk("multi_d", real_rD[63:32], 32'hAAAA_0000);
    chk("multi_src", fwd_src[3:2], 1);
    tick();
    drive(1, 0, 0, 3, 1, 1); cyc();
    drive(1, 3, 0, 4, 1, 0);
    chk_model();
    chk("lu_stall", stall, 1);
    tick();
    chk("lu_cnt", stall_cnt, 1);
    for (int n = 0; n < 5 && stall; n++) cyc();
    chk_model();
    chk("lu_src", fwd_src[1:0], 3);
    chk("lu_d", real_rD[31:0], stage_wD[95:64]);
    tick();
    drive(1, 0, 0, 0, 1, 0); cyc();
    drive(1, 0, 0, 8, 1, 0);
    id_rD = '0;
    stage_wD[31:0] = 32'hFFFF_FFFF;
    chk_model();
    chk("x0_d", real_rD[31:0], 0);
    chk("x0_src", fwd_src[1:0], 0);
    tick();
    drive(1, 0, 0, 3, 1, 1); cyc();
    drive(1, 3, 0, 4, 1, 0);
    chk_model();
    chk("fl_pre", stall, 1);
    flush = 1;
    chk_model();
    chk("fl_stall", stall, 0);
    tick();
    flush = 0;
    drive(1, 3, 0, 4, 1, 0);
    chk_model();
    chk("fl_src", fwd_src[1:0], 0);
    tick();
    for (int i = 0; i < 40; i++) begin
      drive(1, 0, 0, 3, 1, 1); cyc();
      drive(1, 3, 0, 4, 1, 0);
      repeat (3) cyc();
    end
    chk("sat", stall_cnt, (1 << CW) - 1);
    drive(1, 0, 0, 3, 1, 1); cyc();
    drive(1, 3, 0, 4, 1, 0);
    rst = 1;
    chk_model();
    tick();
    rst = 0;
    drive(0, 3, 0, 0, 0, 0);
    chk_model();
    chk("rr_stall", stall, 0);
    chk("rr_cnt", stall_cnt, 0);
    chk("rr_src", fwd_src, 0);
    tick();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(7) != 0, 5'($urandom_range(3)), 5'($urandom_range(3)),
            5'($urandom_range(3)), $urandom_range(3) != 0, $urandom_range(2) == 0);
      flush = $urandom_range(15) == 0;
      rst = $urandom_range(63) == 0;
      cyc();
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
